// File: rtl/bcd_refresh_scheduler_pkg.sv
// bcd_refresh_scheduler_pkg: shared types and sizes for the time-shared BCD converter.
package bcd_refresh_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
    localparam int N_CH = 3;
    localparam int BIN_W = 8;
    localparam int BCD_W = 8;
    localparam int ITER = 8;
    localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (add-3 adjust, then shift {bcd, bin} left).
module bcd_dabble_step
    import bcd_refresh_scheduler_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd_next,
    output logic [BIN_W-1:0] bin_next
);
    logic [3:0] lo, hi;
    assign lo = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
    assign hi = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
    // The bit shifted out of the tens nibble is the hundreds carry and is dropped.
    assign {bcd_next, bin_next} = {hi, lo, bin} << 1;
endmodule

// File: rtl/bcd_refresh_scheduler.sv
// bcd_refresh_scheduler: round-robin sweep of three counters through one shared
// double-dabble engine, producing registered packed-BCD bytes for the VGA text path.
module bcd_refresh_scheduler
    import bcd_refresh_scheduler_pkg::*;
#(
    parameter int MAX_VAL = 99,
    parameter int REFRESH_DIV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] Contador_1,
    input  logic [BIN_W-1:0] Contador_2,
    input  logic [BIN_W-1:0] Contador_3,
    output logic [BCD_W-1:0] VGA_1,
    output logic [BCD_W-1:0] VGA_2,
    output logic [BCD_W-1:0] VGA_3,
    output logic             busy,
    output logic             done
);
    localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);

    state_t           state;
    logic [BIN_W-1:0] snap [N_CH];
    logic [1:0]       ch;
    logic [BCD_W-1:0] bcd, bcd_n, res;
    logic [BIN_W-1:0] bin, bin_n, cur;
    logic [3:0]       iter;
    logic [31:0]      rcnt;
    logic             trig;

    bcd_dabble_step u_step (.bcd(bcd), .bin(bin), .bcd_next(bcd_n), .bin_next(bin_n));

    assign trig = start || (REFRESH_DIV > 0 && rcnt == 32'(REFRESH_DIV - 1));
    assign cur  = snap[ch];
    assign res  = cur > MAX_B ? BCD_ZERO : bcd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            snap  <= '{default: '0};
            ch    <= '0;
            bcd   <= BCD_ZERO;
            bin   <= '0;
            iter  <= '0;
            rcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            VGA_1 <= BCD_ZERO;
            VGA_2 <= BCD_ZERO;
            VGA_3 <= BCD_ZERO;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        // All three channels are captured on the same edge so the display is time-coherent.
                        snap[0] <= Contador_1;
                        snap[1] <= Contador_2;
                        snap[2] <= Contador_3;
                        ch      <= '0;
                        busy    <= 1'b1;
                        rcnt    <= '0;
                        state   <= LOAD;
                    end else if (REFRESH_DIV > 0) begin
                        rcnt <= rcnt + 32'd1;
                    end
                end
                LOAD: begin
                    bin   <= cur;
                    bcd   <= BCD_ZERO;
                    iter  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd  <= bcd_n;
                    bin  <= bin_n;
                    iter <= iter + 4'd1;
                    if (iter == 4'(ITER - 1)) state <= STORE;
                end
                STORE: begin
                    case (ch)
                        2'd0:    VGA_1 <= res;
                        2'd1:    VGA_2 <= res;
                        default: VGA_3 <= res;
                    endcase
                    if (ch == 2'(N_CH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ch    <= ch + 2'd1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_refresh_scheduler.sv
// tb_bcd_refresh_scheduler: directed checks of sweep latency, clamping, snapshot,
// reset abort, auto-refresh and back-to-back operation.
module tb_bcd_refresh_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_r = 1'b0;
    logic [7:0] c1 = 8'd0, c2 = 8'd0, c3 = 8'd0;
    logic [7:0] v1, v2, v3, r1, r2, r3;
    logic       busy, done, r_busy, r_done;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    bcd_refresh_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Contador_1(c1), .Contador_2(c2), .Contador_3(c3),
        .VGA_1(v1), .VGA_2(v2), .VGA_3(v3), .busy(busy), .done(done)
    );

    bcd_refresh_scheduler #(.REFRESH_DIV(50)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start_r),
        .Contador_1(c1), .Contador_2(c2), .Contador_3(c3),
        .VGA_1(r1), .VGA_2(r2), .VGA_3(r3), .busy(r_busy), .done(r_done)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return v > 99 ? 8'h00 : 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_sweep(output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL sweep_timeout got=no_done exp=done_within_40");
        end
    endtask

    task automatic test_reset();
        c1 = 8'd42; c2 = 8'd17; c3 = 8'd5;
        do_reset();
        total++;
        if ({v1, v2, v3} !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%h/%h/%h busy=%b done=%b exp=00/00/00 busy=0 done=0", v1, v2, v3, busy, done);
        end
        total++;
        if ({r1, r2, r3} !== 24'h0 || r_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_r got=%h/%h/%h busy=%b exp=00/00/00 busy=0", r1, r2, r3, r_busy);
        end
    endtask

    task automatic test_basic();
        int nd;
        nd = 0;
        c1 = 8'd59; c2 = 8'd7; c3 = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (done) nd++;
            if (k == 9) begin
                total++;
                if (v1 !== 8'h00) begin bad++; $display("FAIL basic_vga1_early got=%h exp=00", v1); end
            end
            if (k == 10) begin
                total++;
                if (v1 !== 8'h59) begin bad++; $display("FAIL basic_vga1 got=%h exp=59", v1); end
            end
            if (k == 20) begin
                total++;
                if (v2 !== 8'h07) begin bad++; $display("FAIL basic_vga2 got=%h exp=07", v2); end
            end
            if (k == 29) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_pre_done got=busy%b/done%b exp=busy1/done0", busy, done); end
            end
            if (k == 30) begin
                total++;
                if (v3 !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_end got=%h done=%b busy=%b exp=00 done=1 busy=0", v3, done, busy);
                end
            end
        end
        total++;
        if (nd != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_clamp();
        int n;
        c1 = 8'd99; c2 = 8'd100; c3 = 8'd255;
        run_sweep(n);
        total++;
        if (n != 30) begin bad++; $display("FAIL clamp_latency got=%0d exp=30", n); end
        total++;
        if ({v1, v2, v3} !== 24'h990000) begin bad++; $display("FAIL clamp_values got=%h/%h/%h exp=99/00/00", v1, v2, v3); end
    endtask

    task automatic test_all_values();
        int n;
        for (int v = 0; v < 100; v++) begin
            c1 = 8'(v); c2 = 8'(99 - v); c3 = 8'((v * 7) % 100);
            run_sweep(n);
            total++;
            if (v1 !== to_bcd(v) || v2 !== to_bcd(99 - v) || v3 !== to_bcd((v * 7) % 100)) begin
                bad++;
                $display("FAIL sweep_value_%0d got=%h/%h/%h exp=%h/%h/%h", v, v1, v2, v3,
                         to_bcd(v), to_bcd(99 - v), to_bcd((v * 7) % 100));
            end
        end
    endtask

    task automatic test_snapshot();
        int nd;
        nd = 0;
        c1 = 8'd12; c2 = 8'd1; c3 = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) nd++;
            if (k == 2) c1 = 8'd34;
            start = (k == 9);
        end
        start = 1'b0;
        total++;
        if (v1 !== 8'h12) begin bad++; $display("FAIL snapshot_vga1 got=%h exp=12", v1); end
        total++;
        if (nd != 1) begin bad++; $display("FAIL snapshot_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_reset_mid();
        int nd, n;
        nd = 0;
        c1 = 8'd23; c2 = 8'd45; c3 = 8'd56;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        total++;
        if (v1 !== 8'h23 || busy !== 1'b1) begin bad++; $display("FAIL midreset_pre got=%h busy=%b exp=23 busy=1", v1, busy); end
        do_reset();
        total++;
        if ({v1, v2, v3} !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state got=%h/%h/%h busy=%b done=%b exp=00/00/00 busy=0 done=0", v1, v2, v3, busy, done);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) nd++;
        end
        total++;
        if (nd != 0 || {v1, v2, v3} !== 24'h0) begin bad++; $display("FAIL midreset_quiet got=done%0d/%h%h%h exp=done0/000000", nd, v1, v2, v3); end
        run_sweep(n);
        total++;
        if ({v1, v2, v3} !== 24'h234556) begin bad++; $display("FAIL midreset_restart got=%h/%h/%h exp=23/45/56", v1, v2, v3); end
    endtask

    task automatic test_refresh();
        int first, second, nd;
        first = -1; second = -1; nd = 0;
        c1 = 8'd1; c2 = 8'd2; c3 = 8'd3;
        do_reset();
        for (int k = 1; k <= 170; k++) begin
            tick();
            if (k == 49) begin
                total++;
                if (r_busy !== 1'b0) begin bad++; $display("FAIL refresh_idle got=%b exp=0", r_busy); end
            end
            if (k == 50) begin
                total++;
                if (r_busy !== 1'b1) begin bad++; $display("FAIL refresh_selfstart got=%b exp=1", r_busy); end
            end
            if (r_done) begin
                nd++;
                if (nd == 1) first = k;
                if (nd == 2) second = k;
            end
        end
        total++;
        if (first != 80) begin bad++; $display("FAIL refresh_first_done got=%0d exp=80", first); end
        total++;
        if (second - first != 80) begin bad++; $display("FAIL refresh_period got=%0d exp=80", second - first); end
        total++;
        if ({r1, r2, r3} !== 24'h010203) begin bad++; $display("FAIL refresh_values got=%h/%h/%h exp=01/02/03", r1, r2, r3); end
        total++;
        if (busy !== 1'b0 || {v1, v2, v3} !== 24'h0) begin bad++; $display("FAIL refresh_off_idle got=busy%b/%h%h%h exp=busy0/000000", busy, v1, v2, v3); end
    endtask

    task automatic test_back_to_back();
        int nd;
        int at [3];
        nd = 0;
        at = '{-1, -1, -1};
        c1 = 8'd10; c2 = 8'd20; c3 = 8'd30;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 92; k++) begin
            tick();
            if (k == 35) begin c1 = 8'd11; c2 = 8'd21; c3 = 8'd31; end
            if (done) begin
                if (nd < 3) at[nd] = k;
                nd++;
                if (k == 61) begin
                    total++;
                    if ({v1, v2, v3} !== 24'h102030) begin bad++; $display("FAIL b2b_second got=%h/%h/%h exp=10/20/30", v1, v2, v3); end
                end
            end
        end
        start = 1'b0;
        total++;
        if (at[0] != 30 || at[1] != 61 || at[2] != 92) begin
            bad++;
            $display("FAIL b2b_done_times got=%0d/%0d/%0d exp=30/61/92", at[0], at[1], at[2]);
        end
        total++;
        if ({v1, v2, v3} !== 24'h112131) begin bad++; $display("FAIL b2b_third got=%h/%h/%h exp=11/21/31", v1, v2, v3); end
        for (int k = 0; k < 40; k++) tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_settle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_all_values();
        test_snapshot();
        test_reset_mid();
        test_refresh();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
